// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage issuing one load/store at a time, formatting load data and pulsing writeback.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses retire immediately with err_out and no request.
module lsu_mem_stage #(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [3:0]      wmask_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] rd_data_out,
    output logic            rd_we_out,
    output logic [XLEN-1:0] pc_out,
    output logic            err_out
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [1:0]  boff;
    logic [31:0] cnt;
    logic [6:0]  op_in;
    logic        is_mem;
    logic        misalign;
    logic        trap;
    logic        unused_bits;

    assign op_in         = instruction_in[6:0];
    assign is_mem        = op_in == OP_LOAD || op_in == OP_STORE;
    assign trap          = is_mem && misalign;
    assign in_ready      = state == IDLE;
    assign mem_req_valid = state == REQ;
    assign out_valid     = state == DONE;
    assign unused_bits   = ^instruction_in[31:15];

`ifdef MISALIGN_TRAP_EN
    assign misalign = (instruction_in[13:12] == 2'b01 && addr_in[0]) ||
                      (instruction_in[13:12] == 2'b10 && addr_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Lane select uses the raw byte offset, so a halfword at offset 3 reads [31:16].
    function automatic logic [XLEN-1:0] fmt(input logic [31:0] w, input logic [1:0] b, input logic [2:0] f);
        logic [7:0]  by;
        logic [15:0] hw;
        by = w[{b, 3'b000} +: 8];
        hw = b[1] ? w[31:16] : w[15:0];
        fmt = f == 3'b000 ? {{(XLEN-8){by[7]}}, by} :
              f == 3'b001 ? {{(XLEN-16){hw[15]}}, hw} :
              f == 3'b100 ? {{(XLEN-8){1'b0}}, by} :
              f == 3'b101 ? {{(XLEN-16){1'b0}}, hw} : XLEN'(w);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            opc         <= '0;
            f3          <= '0;
            boff        <= '0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wmask   <= '0;
            mem_wdata   <= '0;
            rd_out      <= '0;
            rd_data_out <= '0;
            rd_we_out   <= 1'b0;
            pc_out      <= '0;
            err_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opc         <= op_in;
                    f3          <= instruction_in[14:12];
                    boff        <= addr_in[1:0];
                    mem_addr    <= {addr_in[XLEN-1:2], 2'b00};
                    mem_we      <= op_in == OP_STORE;
                    mem_wmask   <= op_in == OP_STORE ? wmask_in : 4'b0000;
                    mem_wdata   <= store_data_in;
                    rd_out      <= instruction_in[11:7];
                    pc_out      <= pc_in;
                    err_out     <= trap;
                    rd_we_out   <= !is_mem && instruction_in[11:7] != 5'd0 && op_in != OP_BRANCH;
                    rd_data_out <= is_mem ? '0 : result_in;
                    state       <= is_mem && !misalign ? REQ : DONE;
                end
                REQ: if (mem_req_ready) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (mem_rsp_valid) begin
                    state       <= DONE;
                    rd_data_out <= opc == OP_LOAD ? fmt(mem_rdata[31:0], boff, f3) : '0;
                    rd_we_out   <= opc == OP_LOAD && rd_out != 5'd0;
                end else if (RSP_TIMEOUT != 0 && cnt == 32'(RSP_TIMEOUT - 1)) begin
                    state       <= DONE;
                    err_out     <= 1'b1;
                    rd_we_out   <= 1'b0;
                    rd_data_out <= '0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed plus randomized transactions checked against a behavioural model of the stage.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [31:0] addr_in;
    logic [31:0] result_in;
    logic [31:0] store_data_in;
    logic [3:0]  wmask_in;
    logic [31:0] pc_in;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  rd_out;
    logic [31:0] rd_data_out;
    logic        rd_we_out;
    logic [31:0] pc_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.XLEN(32), .RSP_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction_in(instruction_in), .addr_in(addr_in), .result_in(result_in),
        .store_data_in(store_data_in), .wmask_in(wmask_in), .pc_in(pc_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .rd_out(rd_out), .rd_data_out(rd_data_out), .rd_we_out(rd_we_out),
        .pc_out(pc_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
        int unsigned b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * (a[1:0] / 2))) & 32'hFFFF;
        case (f)
            3'd0: return b >= 128 ? b + 32'hFFFF_FF00 : b;
            3'd1: return h >= 32768 ? h + 32'hFFFF_0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_misalign(input logic [31:0] a, input logic [2:0] f);
`ifdef MISALIGN_TRAP_EN
        return (f[1:0] == 2'd1 && a % 2 != 0) || (f[1:0] == 2'd2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // rsp_dly < 0 means the memory never answers.
    task automatic run(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] res, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] pc, input logic [31:0] rdata,
                       input int rdy_dly, input int rsp_dly);
        bit is_load, is_store, trap;
        logic [31:0] exp_data;
        bit exp_we;
        int n;
        is_load  = opc == 7'b0000011;
        is_store = opc == 7'b0100011;
        trap     = (is_load || is_store) && model_misalign(addr, f3);
        chk("in_ready_idle", in_ready, 1);
        instruction_in = {17'($urandom), f3, rd, opc};
        addr_in = addr; result_in = res; store_data_in = wd; wmask_in = wm; pc_in = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        instruction_in = $urandom; addr_in = $urandom; result_in = $urandom;
        if (!(is_load || is_store) || trap) begin
            chk("no_req", mem_req_valid, 0);
            chk("out_valid", out_valid, 1);
            chk("err", err_out, trap);
            chk("rd_we", rd_we_out, !trap && rd != 0 && opc != 7'b1100011);
            chk("rd_data", rd_data_out, trap ? 32'd0 : res);
        end else begin
            chk("req_valid", mem_req_valid, 1);
            chk("in_ready_busy", in_ready, 0);
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            chk("mem_we", mem_we, is_store);
            chk("mem_wmask", mem_wmask, is_store ? wm : 4'd0);
            if (is_store) chk("mem_wdata", mem_wdata, wd);
            mem_rsp_valid = 1'b1;
            mem_rdata = $urandom;
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                chk("req_hold", mem_req_valid, 1);
                chk("addr_hold", mem_addr, {addr[31:2], 2'b00});
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("req_drop", mem_req_valid, 0);
            if (rsp_dly >= 0) begin
                repeat (rsp_dly) @(negedge clk);
                mem_rsp_valid = 1'b1;
                mem_rdata = rdata;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                mem_rdata = $urandom;
                exp_data = is_load ? model_load(rdata, addr, f3) : 32'd0;
                exp_we   = is_load && rd != 0;
                chk("out_valid", out_valid, 1);
                chk("err", err_out, 0);
                chk("rd_we", rd_we_out, exp_we);
                chk("rd_data", rd_data_out, exp_data);
            end else begin
                n = 0;
                while (!out_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_cycles", n, 255);
                chk("timeout_err", err_out, 1);
                chk("timeout_we", rd_we_out, 0);
                chk("timeout_data", rd_data_out, 0);
            end
        end
        chk("rd_out", rd_out, rd);
        chk("pc_out", pc_out, pc);
        @(negedge clk);
        chk("pulse_end", out_valid, 0);
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; instruction_in = '0; addr_in = '0; result_in = '0;
        store_data_in = '0; wmask_in = '0; pc_in = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req", mem_req_valid, 0);
        chk("rst_data", rd_data_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset abandoned mid-REQ: request must drop without waiting for a clock edge.
        instruction_in = {17'd0, 3'd2, 5'd7, 7'b0000011};
        addr_in = 32'h5004; pc_in = 32'h100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_req", mem_req_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_req_drop", mem_req_valid, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_addr", mem_addr, 0);
        chk("async_rd", rd_out, 0);
        chk("async_pc", pc_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        run(7'b0000011, 5'd3, 3'd0, 32'h1003, 0, 0, 0, 32'h10, 32'h80FF_1234, 3, 1);
        run(7'b0000011, 5'd4, 3'd5, 32'h2002, 0, 0, 0, 32'h14, 32'h9ABC_5678, 0, 0);
        run(7'b0000011, 5'd0, 3'd5, 32'h2002, 0, 0, 0, 32'h18, 32'h9ABC_5678, 1, 2);
        run(7'b0100011, 5'd0, 3'd2, 32'h3000, 0, 32'hDEAD_BEEF, 4'hF, 32'h1C, 0, 0, 3);
        run(7'b0010011, 5'd5, 3'd0, 0, 32'h42, 0, 0, 32'h20, 0, 0, 0);
        run(7'b0000011, 5'd6, 3'd2, 32'h4000, 0, 0, 0, 32'h24, 0, 0, -1);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", out_valid, 0);
        chk("late_rsp_idle", in_ready, 1);
        run(7'b0000011, 5'd8, 3'd1, 32'h6003, 0, 0, 0, 32'h28, 32'h8001_7FFF, 0, 0);
`ifdef MISALIGN_TRAP_EN
        run(7'b0000011, 5'd9, 3'd2, 32'h4002, 0, 0, 0, 32'h2C, 0, 0, 0);
`endif

        for (int k = 0; k < 60; k++) begin
            logic [6:0] op;
            logic [2:0] f;
            int sel;
            sel = $urandom_range(0, 4);
            op = sel == 0 ? 7'b0000011 : sel == 1 ? 7'b0100011 : sel == 2 ? 7'b0010011 :
                 sel == 3 ? 7'b1100011 : 7'b0110111;
            f = sel == 1 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run(op, 5'($urandom), f, $urandom, $urandom, $urandom, 4'($urandom),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
